// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared floor width, default floor count, dispatcher states
//               and delay constants for the dispatcher and elevator core.
// Revision    : 1.0
// ============================================================================
package elevator_pkg;

    localparam int          FLOOR_W            = 4;
    localparam int          DEFAULT_NUM_FLOORS = 10;
    localparam logic [31:0] DELAY_COUNT        = 32'd10000000;
    localparam logic [31:0] DWELL_CYCLES       = 32'd10000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/call_selector.sv
`default_nettype none
// ============================================================================
// Module      : call_selector
// Description : Combinational SCAN target picker; also reports the nearest
//               pending floor ahead of the car for in-flight retargeting.
// Revision    : 1.0
// ============================================================================
module call_selector #(
    parameter int NUM_FLOORS = elevator_pkg::DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    next_floor,
    output logic                  next_dir_up,
    output logic                  valid,
    output logic [FLOOR_W-1:0]    ahead_floor,
    output logic                  ahead_valid
);
    import elevator_pkg::*;

    logic [FLOOR_W-1:0] w_above;
    logic [FLOOR_W-1:0] w_below;
    logic               w_above_ok;
    logic               w_below_ok;

    // Lowest pending floor above the car and highest pending floor below it.
    always_comb begin
        w_above    = '0;
        w_above_ok = 1'b0;
        w_below    = '0;
        w_below_ok = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
                w_above    = FLOOR_W'(i);
                w_above_ok = 1'b1;
            end
        end
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (pending[j] && (FLOOR_W'(j) < current_floor)) begin
                w_below    = FLOOR_W'(j);
                w_below_ok = 1'b1;
            end
        end
    end

    always_comb begin
        next_floor  = '0;
        next_dir_up = dir_up;
        valid       = 1'b0;
        if (dir_up) begin
            if (w_above_ok) begin
                next_floor = w_above; next_dir_up = 1'b1; valid = 1'b1;
            end else if (w_below_ok) begin
                next_floor = w_below; next_dir_up = 1'b0; valid = 1'b1;
            end
        end else begin
            if (w_below_ok) begin
                next_floor = w_below; next_dir_up = 1'b0; valid = 1'b1;
            end else if (w_above_ok) begin
                next_floor = w_above; next_dir_up = 1'b1; valid = 1'b1;
            end
        end
        ahead_floor = dir_up ? w_above : w_below;
        ahead_valid = dir_up ? w_above_ok : w_below_ok;
    end

endmodule
`default_nettype wire

// File: rtl/floor_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : floor_call_dispatcher
// Description : Captures floor-call presses and drives the SCAN-ordered target
//               floor for the elevator core, holding each served floor open.
// Revision    : 1.0
// ============================================================================
module floor_call_dispatcher #(
    parameter int          NUM_FLOORS   = elevator_pkg::DEFAULT_NUM_FLOORS,
    parameter int          FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter logic [31:0] DWELL_CYCLES = elevator_pkg::DWELL_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);
    import elevator_pkg::*;

    localparam logic [31:0] C_DWELL_LAST = DWELL_CYCLES - 32'd1;

    disp_state_t           r_state;
    logic [NUM_FLOORS-1:0] r_btn_prev;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FLOOR_W-1:0]    r_req_floor;
    logic                  r_door_open;
    logic                  r_dir_up;
    logic [31:0]           r_dwell_cnt;

    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_cf_mask;
    logic [NUM_FLOORS-1:0] w_rf_mask;
    logic [NUM_FLOORS-1:0] w_clear;
    logic                  w_cf_valid;
    logic                  w_at_cf_call;
    logic                  w_at_target;
    logic                  w_restart;
    logic                  w_retarget;
    logic [FLOOR_W-1:0]    w_sel_floor;
    logic                  w_sel_dir_up;
    logic                  w_sel_valid;
    logic [FLOOR_W-1:0]    w_ahead_floor;
    logic                  w_ahead_valid;

    call_selector #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_selector (
        .pending       (r_pending),
        .current_floor (current_floor),
        .dir_up        (r_dir_up),
        .next_floor    (w_sel_floor),
        .next_dir_up   (w_sel_dir_up),
        .valid         (w_sel_valid),
        .ahead_floor   (w_ahead_floor),
        .ahead_valid   (w_ahead_valid)
    );

    assign w_press      = call_btn & ~r_btn_prev;
    assign w_cf_valid   = 32'(current_floor) < 32'(NUM_FLOORS);
    assign w_cf_mask    = w_cf_valid ? (NUM_FLOORS'(1) << current_floor) : '0;
    assign w_rf_mask    = NUM_FLOORS'(1) << r_req_floor;
    assign w_at_cf_call = |(r_pending & w_cf_mask);
    assign w_at_target  = (current_floor == r_req_floor);
    assign w_restart    = (r_state == ST_DWELL) && (|(w_press & w_cf_mask));
    assign w_retarget   = w_ahead_valid &&
                          (r_dir_up ? (w_ahead_floor < r_req_floor)
                                    : (w_ahead_floor > r_req_floor));

    // Floors whose pending bit is cleared this edge; a clear overrides a press.
    always_comb begin
        w_clear = '0;
        case (r_state)
            ST_IDLE:  if (w_at_cf_call) w_clear = w_cf_mask;
            ST_MOVE:  if (w_at_target) w_clear = w_rf_mask;
            ST_DWELL: w_clear = w_press & w_cf_mask;
            default:  w_clear = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_btn_prev  <= '0;
            r_pending   <= '0;
            r_req_floor <= '0;
            r_door_open <= 1'b0;
            r_dir_up    <= 1'b1;
            r_dwell_cnt <= '0;
        end else begin
            r_btn_prev <= call_btn;
            r_pending  <= (r_pending | w_press) & ~w_clear;
            case (r_state)
                ST_IDLE: begin
                    if (w_cf_valid) begin
                        if (w_at_cf_call) begin
                            r_state     <= ST_DWELL;
                            r_door_open <= 1'b1;
                            r_dwell_cnt <= '0;
                        end else if ((|r_pending) && w_sel_valid) begin
                            r_state     <= ST_MOVE;
                            r_req_floor <= w_sel_floor;
                            r_dir_up    <= w_sel_dir_up;
                        end
                    end
                end
                ST_MOVE: begin
                    if (w_at_target) begin
                        r_state     <= ST_DWELL;
                        r_door_open <= 1'b1;
                        r_dwell_cnt <= '0;
                    end else if (w_retarget) begin
                        r_req_floor <= w_ahead_floor;
                    end
                end
                ST_DWELL: begin
                    if (w_restart) begin
                        r_dwell_cnt <= '0;
                    end else if (r_dwell_cnt == C_DWELL_LAST) begin
                        r_state     <= ST_IDLE;
                        r_door_open <= 1'b0;
                        r_dwell_cnt <= '0;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_door_open <= 1'b0;
                    r_dwell_cnt <= '0;
                end
            endcase
        end
    end

    assign requested_floor = r_req_floor;
    assign pending         = r_pending;
    assign door_open       = r_door_open;
    assign dir_up          = r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_floor_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_call_dispatcher
// Description : Scenario bench for floor_call_dispatcher with a queue of
//               expected results popped as the DUT responds.
// Revision    : 1.0
// ============================================================================
module tb_floor_call_dispatcher;

    localparam int          NF = 10;
    localparam int          FW = 4;
    localparam logic [31:0] DW = 32'd8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] current_floor;
    logic [FW-1:0] requested_floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic          dir_up;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          len;

    always #5 clk = ~clk;

    floor_call_dispatcher #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .call_btn        (call_btn),
        .current_floor   (current_floor),
        .requested_floor (requested_floor),
        .pending         (pending),
        .door_open       (door_open),
        .dir_up          (dir_up)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_dwell(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; call_btn = '0; current_floor = '0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        tick(2);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL reset_rf: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL reset_pending: got %0h want %0h", pending, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(door_open) !== e) begin n_fail++; $display("FAIL reset_door: got %0h want %0h", door_open, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL reset_dir: got %0h want %0h", dir_up, e); end
        reset = 1'b0;
    endtask

    task automatic test_single_call;
        current_floor = 4'd0;
        call_btn[5] = 1'b1; exp_q.push_back(32'h020);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL single_pending: got %0h want %0h", pending, e); end
        call_btn[5] = 1'b0; exp_q.push_back(32'd5); exp_q.push_back(32'd1);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL single_target: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL single_dir: got %0h want %0h", dir_up, e); end
        current_floor = 4'd5; exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(DW);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL single_clear: got %0h want %0h", pending, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(door_open) !== e) begin n_fail++; $display("FAIL single_door: got %0h want %0h", door_open, e); end
        measure_dwell(len);
        e = exp_q.pop_front(); n_checks++; if (32'(len) !== e) begin n_fail++; $display("FAIL single_dwell_len: got %0d want %0d", len, e); end
    endtask

    task automatic test_scan;
        current_floor = 4'd4;
        call_btn[2] = 1'b1; call_btn[7] = 1'b1; exp_q.push_back(32'h084);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL scan_pending: got %0h want %0h", pending, e); end
        call_btn[2] = 1'b0; call_btn[7] = 1'b0; exp_q.push_back(32'd7); exp_q.push_back(32'd1);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL scan_first_target: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL scan_first_dir: got %0h want %0h", dir_up, e); end
        current_floor = 4'd7; exp_q.push_back(32'h004); exp_q.push_back(DW);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL scan_clear7: got %0h want %0h", pending, e); end
        measure_dwell(len);
        e = exp_q.pop_front(); n_checks++; if (32'(len) !== e) begin n_fail++; $display("FAIL scan_dwell_len: got %0d want %0d", len, e); end
        exp_q.push_back(32'd7);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL scan_no_early_load: got %0h want %0h", requested_floor, e); end
        exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL scan_second_target: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL scan_second_dir: got %0h want %0h", dir_up, e); end
        current_floor = 4'd2;
        tick(1);
        measure_dwell(len);
    endtask

    task automatic test_retarget;
        current_floor = 4'd0;
        call_btn[8] = 1'b1; exp_q.push_back(32'h100);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL rt_pending8: got %0h want %0h", pending, e); end
        call_btn[8] = 1'b0; exp_q.push_back(32'd8); exp_q.push_back(32'd1);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rt_target8: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL rt_dir: got %0h want %0h", dir_up, e); end
        current_floor = 4'd3;
        call_btn[6] = 1'b1; exp_q.push_back(32'd8); exp_q.push_back(32'd6);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rt_before_retarget: got %0h want %0h", requested_floor, e); end
        call_btn[6] = 1'b0;
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rt_retarget6: got %0h want %0h", requested_floor, e); end
        call_btn[2] = 1'b1; exp_q.push_back(32'h144); exp_q.push_back(32'd6);
        tick(1);
        call_btn[2] = 1'b0;
        tick(2);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL rt_behind_recorded: got %0h want %0h", pending, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rt_behind_ignored: got %0h want %0h", requested_floor, e); end
    endtask

    task automatic test_reset_mid_move;
        reset = 1'b1;
        tick(1);
        reset = 1'b0; current_floor = 4'd0;
        call_btn[2] = 1'b1; call_btn[5] = 1'b1;
        tick(1);
        call_btn[2] = 1'b0; call_btn[5] = 1'b0;
        tick(1);
        current_floor = 4'd1; exp_q.push_back(32'h024); exp_q.push_back(32'd2);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL rm_pending_pre: got %0h want %0h", pending, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rm_target_pre: got %0h want %0h", requested_floor, e); end
        reset = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        tick(2);
        reset = 1'b0;
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL rm_pending: got %0h want %0h", pending, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL rm_rf: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(door_open) !== e) begin n_fail++; $display("FAIL rm_door: got %0h want %0h", door_open, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL rm_dir: got %0h want %0h", dir_up, e); end
    endtask

    task automatic test_dwell_restart;
        current_floor = 4'd3;
        call_btn[3] = 1'b1; exp_q.push_back(32'h008);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL dr_pending3: got %0h want %0h", pending, e); end
        call_btn[3] = 1'b0; exp_q.push_back(32'd1);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(door_open) !== e) begin n_fail++; $display("FAIL dr_door_open: got %0h want %0h", door_open, e); end
        tick(5);
        call_btn[3] = 1'b1; exp_q.push_back(32'd0); exp_q.push_back(DW);
        tick(1);
        call_btn[3] = 1'b0;
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL dr_press_dropped: got %0h want %0h", pending, e); end
        measure_dwell(len);
        e = exp_q.pop_front(); n_checks++; if (32'(len) !== e) begin n_fail++; $display("FAIL dr_restart_len: got %0d want %0d", len, e); end
    endtask

    task automatic test_held_button_invalid_floor;
        current_floor = 4'd4;
        call_btn[4] = 1'b1; exp_q.push_back(32'h010); exp_q.push_back(32'd0); exp_q.push_back(DW);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL hb_pending4: got %0h want %0h", pending, e); end
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL hb_served: got %0h want %0h", pending, e); end
        measure_dwell(len);
        e = exp_q.pop_front(); n_checks++; if (32'(len) !== e) begin n_fail++; $display("FAIL hb_dwell_len: got %0d want %0d", len, e); end
        exp_q.push_back(32'd0);
        tick(3);
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL hb_held_no_reset: got %0h want %0h", pending, e); end
        call_btn[4] = 1'b0;
        tick(1);
        current_floor = 4'd12; call_btn[4] = 1'b1; exp_q.push_back(32'h010);
        tick(1);
        call_btn[4] = 1'b0;
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL hb_repress: got %0h want %0h", pending, e); end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h010);
        tick(4);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL inv_rf_held: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(door_open) !== e) begin n_fail++; $display("FAIL inv_door: got %0h want %0h", door_open, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(pending) !== e) begin n_fail++; $display("FAIL inv_pending: got %0h want %0h", pending, e); end
        current_floor = 4'd0; exp_q.push_back(32'd4); exp_q.push_back(32'd1);
        tick(1);
        e = exp_q.pop_front(); n_checks++; if (32'(requested_floor) !== e) begin n_fail++; $display("FAIL inv_recover_target: got %0h want %0h", requested_floor, e); end
        e = exp_q.pop_front(); n_checks++; if (32'(dir_up) !== e) begin n_fail++; $display("FAIL inv_recover_dir: got %0h want %0h", dir_up, e); end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan();
        test_retarget();
        test_reset_mid_move();
        test_dwell_restart();
        test_held_button_invalid_floor();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
